// File: rtl/logic16_arb.sv
// Two-requester round-robin arbiter in front of a NOT/AND/OR/NAND logic unit.
// Each operation is accepted, executed for one cycle and held until it is consumed.
module logic16_not #(
   parameter int N = 16
) (
   input  logic [N-1:0] a_i,
   output logic [N-1:0] y_o
);
   assign y_o = ~a_i;
endmodule

module logic16_and #(
   parameter int N = 16
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] y_o
);
   assign y_o = a_i & b_i;
endmodule

module logic16_or #(
   parameter int N = 16
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] y_o
);
   assign y_o = a_i | b_i;
endmodule

module logic16_arb #(
   parameter int N = 16
) (
   input  logic         in_clk,
   input  logic         in_rst_n,
   input  logic         in_req0_valid,
   input  logic         in_req1_valid,
   input  logic [1:0]   in_req0_op,
   input  logic [1:0]   in_req1_op,
   input  logic [N-1:0] in_req0_a,
   input  logic [N-1:0] in_req0_b,
   input  logic [N-1:0] in_req1_a,
   input  logic [N-1:0] in_req1_b,
   output logic         out_req0_ready,
   output logic         out_req1_ready,
   output logic         out_rsp_valid,
   output logic         out_rsp_id,
   output logic [N-1:0] out_rsp_y,
   input  logic         in_rsp_ready,
   output logic         out_busy
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic         ptr_q;
   logic [1:0]   op_q;
   logic [N-1:0] a_q, b_q;
   logic         id_q;
   logic         rsp_valid_q, rsp_id_q;
   logic [N-1:0] rsp_y_q;

   logic         gnt0, gnt1, acc;
   logic [N-1:0] not_y, and_y, or_y, nand_y, res;

   // A lone requester wins regardless of the pointer
   assign gnt0 = in_req0_valid & (~in_req1_valid | ~ptr_q);
   assign gnt1 = in_req1_valid & (~in_req0_valid | ptr_q);
   assign acc  = out_req0_ready | out_req1_ready;

   logic16_not #(.N(N)) u_not  (.a_i(a_q), .y_o(not_y));
   logic16_and #(.N(N)) u_and  (.a_i(a_q), .b_i(b_q), .y_o(and_y));
   logic16_or  #(.N(N)) u_or   (.a_i(a_q), .b_i(b_q), .y_o(or_y));
   logic16_not #(.N(N)) u_nand (.a_i(and_y), .y_o(nand_y));

   always_comb begin
      res = not_y;
      unique case (op_q)
         2'b00:   res = not_y;
         2'b01:   res = and_y;
         2'b10:   res = or_y;
         default: res = nand_y;
      endcase
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (acc) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (in_rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_req0_ready = 1'b0;
      out_req1_ready = 1'b0;
      out_busy       = (state_q != IDLE);
      if (in_rst_n && state_q == IDLE) begin
         out_req0_ready = gnt0;
         out_req1_ready = gnt1;
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         ptr_q       <= 1'b0;
         op_q        <= 2'b00;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_y_q     <= '0;
      end else begin
         if (acc) begin
            op_q  <= gnt1 ? in_req1_op : in_req0_op;
            a_q   <= gnt1 ? in_req1_a : in_req0_a;
            b_q   <= gnt1 ? in_req1_b : in_req0_b;
            id_q  <= gnt1;
            ptr_q <= ~gnt1;
         end
         if (state_q == EXEC) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_y_q     <= res;
         end else if (state_q == RESP && in_rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign out_rsp_valid = rsp_valid_q;
   assign out_rsp_id    = rsp_id_q;
   assign out_rsp_y     = rsp_y_q;
endmodule
